mips_cpu_mem_arbiter: RTL and testbench

Single-port Avalon-MM master arbiter between the data cache's read-miss line fill and the cache write buffer's drain port. It sits directly downstream of the write buffer: it consumes the buffer's head entry and drives the buffer's `active` and `waitrequest` inputs. Read misses take priority, except when the missed line may still have pending data in the buffer; in that case the buffer is drained first to keep memory coherent. Every Avalon transaction runs to completion before the bus changes owner.

---
 rtl/mips_cpu_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_arbiter.sv
// Avalon-MM master arbiter between the data cache line fill and the write buffer drain.
// Reads win, unless the missed line may still have pending data in the buffer.
module mips_cpu_mem_arbiter #(
   parameter int unsigned LINE_BITS  = 2,
   parameter int unsigned LINE_WORDS = 2 ** LINE_BITS
) (
   input  logic                 clk,
   input  logic                 rst,

   // cache read-miss port
   input  logic                 rd_req,
   input  logic [31:0]          rd_addr,
   output logic                 rd_valid,
   output logic [LINE_BITS-1:0] rd_word,
   output logic [31:0]          rd_data,
   output logic                 rd_done,

   // write buffer head
   input  logic                 wb_write,
   input  logic [31:0]          wb_addr,
   input  logic [31:0]          wb_data,
   input  logic [3:0]           wb_byteenable,
   input  logic                 wb_empty,
   input  logic                 wb_hit,
   output logic                 wb_active,
   output logic                 wb_waitrequest,

   // Avalon-MM master
   output logic [31:0]          avm_address,
   output logic                 avm_read,
   output logic                 avm_write,
   output logic [31:0]          avm_writedata,
   output logic [3:0]           avm_byteenable,
   input  logic [31:0]          avm_readdata,
   input  logic                 avm_waitrequest
);

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain
   } state_e;

   localparam logic [LINE_BITS-1:0] LastWord = LINE_BITS'(LINE_WORDS - 1);

   state_e               state_q, state_d;
   logic [LINE_BITS-1:0] cnt_q, cnt_d;

   logic wr_stall;
   logic rd_beat;
   logic rd_last;

   // Low address bits select the word within the line and come from cnt instead.
   logic unused_rd_addr;
   assign unused_rd_addr = ^rd_addr[LINE_BITS+1:0];

   assign wr_stall = wb_write && avm_waitrequest;
   assign rd_beat  = !avm_waitrequest;
   assign rd_last  = (cnt_q == LastWord);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rd_valid       = 1'b0;
      rd_word        = '0;
      rd_data        = '0;
      rd_done        = 1'b0;
      wb_active      = 1'b0;
      wb_waitrequest = 1'b1;
      avm_address    = '0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = '0;
      avm_byteenable = '0;

      unique case (state_q)
         StIdle: begin
            if (rd_req) begin
               if (wb_hit) begin
                  state_d = StDrain;
               end else begin
                  state_d = StRead;
                  cnt_d   = '0;
               end
            end else if (!wb_empty) begin
               state_d = StWrite;
            end
         end

         StWrite, StDrain: begin
            wb_active      = 1'b1;
            wb_waitrequest = avm_waitrequest;
            avm_write      = wb_write;
            avm_address    = wb_addr;
            avm_writedata  = wb_data;
            avm_byteenable = wb_byteenable;
            // A stalled write owns the bus until it completes.
            if (!wr_stall) begin
               if (state_q == StDrain) begin
                  if (wb_empty) begin
                     state_d = StRead;
                     cnt_d   = '0;
                  end
               end else if (rd_req) begin
                  if (wb_hit) begin
                     state_d = StDrain;
                  end else begin
                     state_d = StRead;
                     cnt_d   = '0;
                  end
               end else if (wb_empty) begin
                  state_d = StIdle;
               end
            end
         end

         StRead: begin
            avm_read       = 1'b1;
            avm_byteenable = 4'hF;
            avm_address    = {rd_addr[31:LINE_BITS+2], cnt_q, 2'b00};
            if (rd_beat) begin
               rd_valid = 1'b1;
               rd_word  = cnt_q;
               rd_data  = avm_readdata;
               cnt_d    = cnt_q + 1'b1;
               if (rd_last) begin
                  rd_done = 1'b1;
                  cnt_d   = '0;
                  state_d = wb_empty ? StIdle : StWrite;
               end
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter: inputs driven on the falling edge,
// outputs checked 1 ns later with immediate assertions.
module tb_mips_cpu_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_valid;
   logic [1:0]  rd_word;
   logic [31:0] rd_data;
   logic        rd_done;
   logic        wb_write;
   logic [31:0] wb_addr;
   logic [31:0] wb_data;
   logic [3:0]  wb_byteenable;
   logic        wb_empty;
   logic        wb_hit;
   logic        wb_active;
   logic        wb_waitrequest;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   int vectors    = 0;
   int miscompares = 0;

   mips_cpu_mem_arbiter #(
      .LINE_BITS (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rd_req          (rd_req),
      .rd_addr         (rd_addr),
      .rd_valid        (rd_valid),
      .rd_word         (rd_word),
      .rd_data         (rd_data),
      .rd_done         (rd_done),
      .wb_write        (wb_write),
      .wb_addr         (wb_addr),
      .wb_data         (wb_data),
      .wb_byteenable   (wb_byteenable),
      .wb_empty        (wb_empty),
      .wb_hit          (wb_hit),
      .wb_active       (wb_active),
      .wb_waitrequest  (wb_waitrequest),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // One line word: 'waits' stalled cycles, then the accepted beat.
   task automatic read_word(input int i, input logic [31:0] base, input int waits);
      logic [31:0] addr;
      addr = base + 32'(4 * i);
      for (int w = 0; w < waits; w++) begin
         step();
         avm_waitrequest = 1'b1;
         avm_readdata    = 32'hDEAD_BEEF;
         #1;
         chk("rd_stall_read", avm_read, 1);
         chk("rd_stall_addr", avm_address, addr);
         chk("rd_stall_valid", rd_valid, 0);
      end
      step();
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'hC0DE_0000 | 32'(i);
      #1;
      chk("rd_read", avm_read, 1);
      chk("rd_nowrite", avm_write, 0);
      chk("rd_addr", avm_address, addr);
      chk("rd_be", avm_byteenable, 32'hF);
      chk("rd_valid", rd_valid, 1);
      chk("rd_word", rd_word, 32'(i));
      chk("rd_data", rd_data, 32'hC0DE_0000 | 32'(i));
      chk("rd_done", rd_done, (i == 3) ? 1 : 0);
   endtask

   task automatic read_line(input logic [31:0] base, input int w0, input int w1,
                            input int w2, input int w3);
      read_word(0, base, w0);
      read_word(1, base, w1);
      read_word(2, base, w2);
      read_word(3, base, w3);
   endtask

   task automatic write_entry(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input int waits);
      for (int w = 0; w < waits; w++) begin
         step();
         wb_write        = 1'b1;
         wb_addr         = addr;
         wb_data         = data;
         wb_byteenable   = be;
         avm_waitrequest = 1'b1;
         #1;
         chk("wr_stall_write", avm_write, 1);
         chk("wr_stall_noread", avm_read, 0);
         chk("wr_stall_addr", avm_address, addr);
         chk("wr_stall_wbwait", wb_waitrequest, 1);
         chk("wr_stall_active", wb_active, 1);
      end
      step();
      wb_write        = 1'b1;
      wb_addr         = addr;
      wb_data         = data;
      wb_byteenable   = be;
      avm_waitrequest = 1'b0;
      #1;
      chk("wr_write", avm_write, 1);
      chk("wr_noread", avm_read, 0);
      chk("wr_addr", avm_address, addr);
      chk("wr_data", avm_writedata, data);
      chk("wr_be", avm_byteenable, 32'(be));
      chk("wr_wbwait", wb_waitrequest, 0);
   endtask

   // Buffer goes empty: one more WRITE cycle, then IDLE.
   task automatic finish_writes();
      step();
      wb_write = 1'b0;
      wb_empty = 1'b1;
      #1;
      chk("fin_active", wb_active, 1);
      chk("fin_nowrite", avm_write, 0);
      step();
      #1;
      chk("fin_idle_active", wb_active, 0);
      chk("fin_idle_wbwait", wb_waitrequest, 1);
   endtask

   initial begin
      rst             = 1'b0;
      rd_req          = 1'b0;
      rd_addr         = '0;
      wb_write        = 1'b0;
      wb_addr         = '0;
      wb_data         = '0;
      wb_byteenable   = '0;
      wb_empty        = 1'b1;
      wb_hit          = 1'b0;
      avm_readdata    = '0;
      avm_waitrequest = 1'b0;

      // Reset state
      #2;
      chk("rst_read", avm_read, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_active", wb_active, 0);
      chk("rst_wbwait", wb_waitrequest, 1);
      chk("rst_valid", rd_valid, 0);
      chk("rst_done", rd_done, 0);
      chk("rst_addr", avm_address, 0);
      chk("rst_wdata", avm_writedata, 0);
      chk("rst_be", avm_byteenable, 0);
      step();
      step();
      rst = 1'b1;

      // Clean line fill
      step();
      rd_req  = 1'b1;
      rd_addr = 32'h1000_0034;
      #1;
      chk("fill_req_cycle", avm_read, 0);
      read_line(32'h1000_0030, 0, 0, 0, 0);
      rd_req = 1'b0;
      step();
      #1;
      chk("fill_idle_read", avm_read, 0);
      chk("fill_idle_valid", rd_valid, 0);

      // Write drain, one wait state per entry
      step();
      wb_empty = 1'b0;
      #1;
      chk("drain_idle_active", wb_active, 0);
      chk("drain_idle_write", avm_write, 0);
      write_entry(32'h2000_0000, 32'h1111_1111, 4'hF, 1);
      write_entry(32'h2000_0004, 32'h2222_2222, 4'h3, 1);
      write_entry(32'h2000_0010, 32'h3333_3333, 4'h8, 1);
      finish_writes();

      // Read preempts writes: stalled write finishes first
      step();
      wb_empty = 1'b0;
      step();
      wb_write        = 1'b1;
      wb_addr         = 32'h0000_2000;
      wb_data         = 32'hAAAA_0001;
      wb_byteenable   = 4'hF;
      avm_waitrequest = 1'b1;
      rd_req          = 1'b1;
      rd_addr         = 32'h3000_0008;
      wb_hit          = 1'b0;
      #1;
      chk("pre_stall1_write", avm_write, 1);
      chk("pre_stall1_noread", avm_read, 0);
      step();
      #1;
      chk("pre_stall2_write", avm_write, 1);
      chk("pre_stall2_addr", avm_address, 32'h0000_2000);
      step();
      avm_waitrequest = 1'b0;
      #1;
      chk("pre_done_write", avm_write, 1);
      chk("pre_done_wbwait", wb_waitrequest, 0);
      step();
      wb_write        = 1'b0;
      wb_addr         = 32'h0000_2004;
      wb_data         = 32'hBBBB_0002;
      avm_waitrequest = 1'b1;
      #1;
      chk("pre_read_start", avm_read, 1);
      chk("pre_read_nowrite", avm_write, 0);
      chk("pre_read_addr", avm_address, 32'h3000_0000);
      chk("pre_read_active", wb_active, 0);
      chk("pre_read_wbwait", wb_waitrequest, 1);
      read_line(32'h3000_0000, 0, 0, 0, 0);
      rd_req = 1'b0;
      write_entry(32'h0000_2004, 32'hBBBB_0002, 4'hF, 0);
      finish_writes();

      // Coherency drain: hit forces writes ahead of the read
      step();
      rd_req   = 1'b1;
      rd_addr  = 32'h4000_0000;
      wb_hit   = 1'b1;
      wb_empty = 1'b0;
      #1;
      chk("coh_idle_read", avm_read, 0);
      write_entry(32'h4000_0004, 32'h5555_5555, 4'hF, 0);
      write_entry(32'h4000_0008, 32'h6666_6666, 4'hC, 1);
      step();
      wb_write = 1'b0;
      wb_empty = 1'b1;
      wb_hit   = 1'b0;
      #1;
      chk("coh_empty_noread", avm_read, 0);
      chk("coh_empty_active", wb_active, 1);
      read_line(32'h4000_0000, 0, 1, 0, 0);
      rd_req = 1'b0;
      step();
      #1;
      chk("coh_idle_after", avm_read, 0);

      // Wait states on read
      step();
      rd_req  = 1'b1;
      rd_addr = 32'h5000_0014;
      #1;
      chk("ws_req_cycle", avm_read, 0);
      read_line(32'h5000_0010, 2, 0, 3, 1);
      rd_req = 1'b0;

      // Reset mid-READ with the bus stalled
      step();
      rd_req  = 1'b1;
      rd_addr = 32'h6000_0000;
      read_word(0, 32'h6000_0000, 0);
      step();
      avm_waitrequest = 1'b1;
      #1;
      chk("mid_read", avm_read, 1);
      chk("mid_addr", avm_address, 32'h6000_0004);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_read", avm_read, 0);
      chk("mid_rst_write", avm_write, 0);
      chk("mid_rst_addr", avm_address, 0);
      chk("mid_rst_wbwait", wb_waitrequest, 1);
      chk("mid_rst_valid", rd_valid, 0);
      step();
      rst             = 1'b1;
      rd_req          = 1'b0;
      avm_waitrequest = 1'b0;
      #1;
      chk("post_rst_idle", avm_read, 0);
      step();
      rd_req  = 1'b1;
      rd_addr = 32'h7000_0008;
      #1;
      chk("post_rst_req", avm_read, 0);
      read_line(32'h7000_0000, 0, 0, 0, 0);
      rd_req = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
